// File: rtl/ifu_pc_ctrl.sv
// Instruction-fetch sequencer: boots the PC, fetches one instruction at a time,
// hands it to the EXU and selects the next PC (sequential, redirect, trap or fault).
module ifu_pc_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VEC  = 32'h8000_0000,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_wen,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic                  ifu_req_valid,
    output logic [DATA_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_req_ready,
    input  logic                  ifu_rsp_valid,
    input  logic [31:0]           ifu_rsp_inst,
    input  logic                  ifu_rsp_err,
    output logic                  exu_inst_valid,
    output logic [31:0]           exu_inst,
    input  logic                  exu_inst_ready,
    input  logic                  exu_done,
    input  logic                  exu_redirect,
    input  logic [DATA_WIDTH-1:0] exu_target,
    input  logic                  exu_trap,
    input  logic                  exu_halt,
    input  logic [DATA_WIDTH-1:0] trap_vec,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fault_pc,
    output logic                  halted,
    output logic [63:0]           retire_cnt
);

    typedef enum logic [2:0] {
        S_BOOT, S_REQ, S_WAIT_RSP, S_ISSUE, S_EXEC, S_HALT
    } state_e;

    // Fault fires in the cycle the counter would reach TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [31:0]           exu_inst_q, exu_inst_d;
    logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;
    logic [63:0]           retire_cnt_q, retire_cnt_d;
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
    logic [DATA_WIDTH-1:0] pc_inc;

    assign pc_inc       = pc + DATA_WIDTH'(4);
    assign ifu_req_addr = pc;
    assign exu_inst     = exu_inst_q;
    assign fault_pc     = fault_pc_q;
    assign retire_cnt   = retire_cnt_q;

    always_comb begin
        state_d        = state_q;
        exu_inst_d     = exu_inst_q;
        fault_pc_d     = fault_pc_q;
        retire_cnt_d   = retire_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        pc_wen         = 1'b0;
        next_pc        = pc_inc;
        ifu_req_valid  = 1'b0;
        exu_inst_valid = 1'b0;
        fault          = 1'b0;
        halted         = 1'b0;
        case (state_q)
            S_BOOT: begin
                pc_wen  = 1'b1;
                next_pc = RESET_VEC;
                state_d = S_REQ;
            end
            S_REQ: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (ifu_rsp_valid && !ifu_rsp_err) begin
                    exu_inst_d = ifu_rsp_inst;
                    state_d    = S_ISSUE;
                end else if (ifu_rsp_valid || tmo_cnt_q == TMO_LAST) begin
                    fault      = 1'b1;
                    fault_pc_d = pc;
                    pc_wen     = 1'b1;
                    next_pc    = trap_vec;
                    state_d    = S_REQ;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_ISSUE: begin
                exu_inst_valid = 1'b1;
                if (exu_inst_ready) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exu_done) begin
                    retire_cnt_d = retire_cnt_q + 64'd1;
                    if (exu_halt) begin
                        state_d = S_HALT;
                    end else begin
                        pc_wen  = 1'b1;
                        state_d = S_REQ;
                        if (exu_trap) begin
                            next_pc = trap_vec;
                        end else if (exu_redirect && exu_target[1:0] != 2'b00) begin
                            fault      = 1'b1;
                            fault_pc_d = pc;
                            next_pc    = trap_vec;
                        end else if (exu_redirect) begin
                            next_pc = exu_target;
                        end
                    end
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_BOOT;
            exu_inst_q   <= '0;
            fault_pc_q   <= '0;
            retire_cnt_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            exu_inst_q   <= exu_inst_d;
            fault_pc_q   <= fault_pc_d;
            retire_cnt_q <= retire_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Directed bench for ifu_pc_ctrl with a behavioural PC register and
// hand-driven memory/EXU handshakes.
module tb_ifu_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc = 32'h0;
    logic        pc_wen;
    logic [31:0] next_pc;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic        ifu_rsp_err;
    logic        exu_inst_valid;
    logic [31:0] exu_inst;
    logic        exu_inst_ready;
    logic        exu_done;
    logic        exu_redirect;
    logic [31:0] exu_target;
    logic        exu_trap;
    logic        exu_halt;
    logic [31:0] trap_vec;
    logic        fault;
    logic [31:0] fault_pc;
    logic        halted;
    logic [63:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] TVEC = 32'h8000_0400;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    ifu_pc_ctrl #(.DATA_WIDTH(32), .RESET_VEC(32'h8000_0000), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_wen(pc_wen), .next_pc(next_pc),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
        .ifu_req_ready(ifu_req_ready), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_err(ifu_rsp_err),
        .exu_inst_valid(exu_inst_valid), .exu_inst(exu_inst),
        .exu_inst_ready(exu_inst_ready), .exu_done(exu_done),
        .exu_redirect(exu_redirect), .exu_target(exu_target),
        .exu_trap(exu_trap), .exu_halt(exu_halt), .trap_vec(trap_vec),
        .fault(fault), .fault_pc(fault_pc), .halted(halted), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // The existing PC register this block drives.
    always @(posedge clk) if (pc_wen) pc <= next_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in a REQ cycle; fetch, issue and complete one instruction.
    task automatic run_instr(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                             input logic redir, input logic trap, input logic halt,
                             input logic [31:0] tgt, input logic [31:0] exp_next,
                             input logic exp_fault);
        ifu_req_ready = 1'b1;
        #1;
        chk({tag, ".req_valid"}, 64'(ifu_req_valid), 64'd1);
        chk({tag, ".req_addr"}, 64'(ifu_req_addr), 64'(addr));
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;
        #1;
        chk({tag, ".wait_no_issue"}, 64'(exu_inst_valid), 64'd0);
        tick();
        ifu_rsp_valid  = 1'b0;
        exu_inst_ready = 1'b1;
        #1;
        chk({tag, ".issue_valid"}, 64'(exu_inst_valid), 64'd1);
        chk({tag, ".issue_inst"}, 64'(exu_inst), 64'(inst));
        tick();
        exu_inst_ready = 1'b0;
        exu_done       = 1'b1;
        exu_redirect   = redir;
        exu_trap       = trap;
        exu_halt       = halt;
        exu_target     = tgt;
        #1;
        chk({tag, ".pc_wen"}, 64'(pc_wen), 64'(!halt));
        if (!halt) chk({tag, ".next_pc"}, 64'(next_pc), 64'(exp_next));
        chk({tag, ".fault"}, 64'(fault), 64'(exp_fault));
        tick();
        exu_done     = 1'b0;
        exu_redirect = 1'b0;
        exu_trap     = 1'b0;
        exu_halt     = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0; ifu_rsp_err = 0;
        exu_inst_ready = 0; exu_done = 0; exu_redirect = 0; exu_target = 0;
        exu_trap = 0; exu_halt = 0; trap_vec = TVEC;

        // Reset state
        tick(); tick();
        #1;
        chk("rst.pc_wen", 64'(pc_wen), 64'd1);
        chk("rst.next_pc", 64'(next_pc), 64'h8000_0000);
        chk("rst.req_valid", 64'(ifu_req_valid), 64'd0);
        chk("rst.retire", retire_cnt, 64'd0);
        chk("rst.fault_pc", 64'(fault_pc), 64'd0);
        chk("rst.exu_inst", 64'(exu_inst), 64'd0);
        chk("rst.halted", 64'(halted), 64'd0);
        rst = 1'b1;
        tick();

        // Sequential fetch of three nops
        run_instr("seq0", 32'h8000_0000, NOP, 0, 0, 0, 0, 32'h8000_0004, 0);
        run_instr("seq1", 32'h8000_0004, NOP, 0, 0, 0, 0, 32'h8000_0008, 0);
        run_instr("seq2", 32'h8000_0008, 32'h0010_0093, 0, 0, 0, 0, 32'h8000_000C, 0);
        chk("seq.retire", retire_cnt, 64'd3);

        // Request backpressure: valid and address hold
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.req_valid", 64'(ifu_req_valid), 64'd1);
            chk("bp.req_addr", 64'(ifu_req_addr), 64'h8000_000C);
            tick();
        end
        run_instr("redir", 32'h8000_000C, NOP, 1, 0, 0, 32'h8000_0100, 32'h8000_0100, 0);
        chk("redir.retire", retire_cnt, 64'd4);

        // Misaligned redirect
        run_instr("misal", 32'h8000_0100, NOP, 1, 0, 0, 32'h8000_0102, TVEC, 1);
        chk("misal.fault_pc", 64'(fault_pc), 64'h8000_0100);
        chk("misal.fault_pulse", 64'(fault), 64'd0);
        chk("misal.req_addr", 64'(ifu_req_addr), 64'(TVEC));

        // Fetch bus error at 0x8000_0010
        run_instr("toerr", TVEC, NOP, 1, 0, 0, 32'h8000_0010, 32'h8000_0010, 0);
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_err   = 1'b1;
        #1;
        chk("err.fault", 64'(fault), 64'd1);
        chk("err.pc_wen", 64'(pc_wen), 64'd1);
        chk("err.next_pc", 64'(next_pc), 64'(TVEC));
        tick();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
        #1;
        chk("err.fault_pc", 64'(fault_pc), 64'h8000_0010);
        chk("err.req_addr", 64'(ifu_req_addr), 64'(TVEC));
        chk("err.retire", retire_cnt, 64'd6);

        // Fetch timeout: fault exactly 8 cycles after the handshake
        run_instr("totmo", TVEC, NOP, 1, 0, 0, 32'h8000_0010, 32'h8000_0010, 0);
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        for (int i = 1; i < 8; i++) begin
            #1;
            chk("tmo.early", 64'(fault), 64'd0);
            tick();
        end
        #1;
        chk("tmo.fault", 64'(fault), 64'd1);
        chk("tmo.next_pc", 64'(next_pc), 64'(TVEC));
        tick();
        chk("tmo.fault_pc", 64'(fault_pc), 64'h8000_0010);
        chk("tmo.req_addr", 64'(ifu_req_addr), 64'(TVEC));

        // Trap beats redirect
        run_instr("trap", TVEC, NOP, 1, 1, 0, 32'h8000_0100, TVEC, 0);
        chk("trap.retire", retire_cnt, 64'd8);

        // Reset in the middle of WAIT_RSP
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        rst = 1'b0;
        tick();
        #1;
        chk("wrst.retire", retire_cnt, 64'd0);
        chk("wrst.exu_valid", 64'(exu_inst_valid), 64'd0);
        chk("wrst.exu_inst", 64'(exu_inst), 64'd0);
        chk("wrst.pc_wen", 64'(pc_wen), 64'd1);
        chk("wrst.next_pc", 64'(next_pc), 64'h8000_0000);
        rst = 1'b1;
        tick();
        #1;
        chk("wrst.req_addr", 64'(ifu_req_addr), 64'h8000_0000);

        // Halt wins over trap; fetching stops
        run_instr("halt", 32'h8000_0000, NOP, 0, 1, 1, 0, 0, 0);
        chk("halt.halted", 64'(halted), 64'd1);
        chk("halt.retire", retire_cnt, 64'd1);
        ifu_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt.no_req", 64'(ifu_req_valid), 64'd0);
            tick();
        end
        chk("halt.still", 64'(halted), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
